// File: rtl/configure.sv
// Shared configuration for the core/memory slice: memory geometry plus the
// arbiter's state encoding and buffered request record.
package configure;

    localparam int memory_depth = 14;

    typedef enum logic [1:0] {IDLE, BUSY_I, BUSY_D} arbiter_state_t;

    typedef struct packed {
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  wstrb;
    } arbiter_req_t;

endpackage

// File: rtl/arbiter_buffer.sv
// One-entry request buffer for a single requester port: captures a request,
// keeps it pending until the arbiter completes it, and locks it once issued.
module arbiter_buffer
    import configure::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        valid,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    input  logic [3:0]  wstrb,
    input  logic        issue,
    input  logic        done,
    output logic        avail,
    output logic [31:0] req_addr,
    output logic [31:0] req_wdata,
    output logic [3:0]  req_wstrb
);

    arbiter_req_t stored_reg;
    arbiter_req_t incoming;
    arbiter_req_t selected;
    logic         pending_reg;
    logic         issued_reg;
    logic         capture;

    assign incoming = '{addr: addr, wdata: wdata, wstrb: wstrb};

    // An issued request is frozen; a new valid is only taken once it completes.
    assign capture  = valid && (!issued_reg || done);
    assign avail    = !issued_reg && (pending_reg || valid);
    assign selected = (valid && !issued_reg) ? incoming : stored_reg;

    assign req_addr  = selected.addr;
    assign req_wdata = selected.wdata;
    assign req_wstrb = selected.wstrb;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            stored_reg  <= '0;
            pending_reg <= 1'b0;
            issued_reg  <= 1'b0;
        end else begin
            if (capture) begin
                stored_reg  <= incoming;
                pending_reg <= 1'b1;
            end else if (done) begin
                pending_reg <= 1'b0;
            end

            if (issue) begin
                issued_reg <= 1'b1;
            end else if (done) begin
                issued_reg <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/memory_arbiter.sv
// Shares one memory port between instruction fetch and load/store.
// Define ARBITER_RR_EN for round-robin grant on conflict; default is data priority.
module memory_arbiter
    import configure::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        imem_valid,
    input  logic [31:0] imem_addr,
    output logic [31:0] imem_rdata,
    output logic        imem_ready,
    input  logic        dmem_valid,
    input  logic [31:0] dmem_addr,
    input  logic [31:0] dmem_wdata,
    input  logic [3:0]  dmem_wstrb,
    output logic [31:0] dmem_rdata,
    output logic        dmem_ready,
    output logic        memory_valid,
    output logic        memory_instr,
    output logic [31:0] memory_addr,
    output logic [31:0] memory_wdata,
    output logic [3:0]  memory_wstrb,
    input  logic [31:0] memory_rdata,
    input  logic        memory_ready
);

    arbiter_state_t state_reg;
    arbiter_state_t state_next;

    logic         i_avail;
    logic         d_avail;
    logic         i_issue;
    logic         d_issue;
    logic         i_done;
    logic         d_done;
    logic         prefer_d;
    arbiter_req_t i_req;
    arbiter_req_t d_req;
    arbiter_req_t grant_req;

    arbiter_buffer u_ibuf (
        .clk       (clk),
        .rst       (rst),
        .valid     (imem_valid),
        .addr      (imem_addr),
        .wdata     (32'd0),
        .wstrb     (4'd0),
        .issue     (i_issue),
        .done      (i_done),
        .avail     (i_avail),
        .req_addr  (i_req.addr),
        .req_wdata (i_req.wdata),
        .req_wstrb (i_req.wstrb)
    );

    arbiter_buffer u_dbuf (
        .clk       (clk),
        .rst       (rst),
        .valid     (dmem_valid),
        .addr      (dmem_addr),
        .wdata     (dmem_wdata),
        .wstrb     (dmem_wstrb),
        .issue     (d_issue),
        .done      (d_done),
        .avail     (d_avail),
        .req_addr  (d_req.addr),
        .req_wdata (d_req.wdata),
        .req_wstrb (d_req.wstrb)
    );

`ifdef ARBITER_RR_EN
    // Remembers whether the most recent issue went to the fetch port.
    logic last_instr_reg;

    assign prefer_d = last_instr_reg;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            last_instr_reg <= 1'b1;
        end else if (i_issue || d_issue) begin
            last_instr_reg <= i_issue;
        end
    end
`else
    assign prefer_d = 1'b1;
`endif

    assign i_done = (state_reg == BUSY_I) && memory_ready;
    assign d_done = (state_reg == BUSY_D) && memory_ready;

    always_comb begin
        i_issue = 1'b0;
        d_issue = 1'b0;
        case (state_reg)
            IDLE: begin
                if (d_avail && (!i_avail || prefer_d)) begin
                    d_issue = 1'b1;
                end else if (i_avail) begin
                    i_issue = 1'b1;
                end
            end
            BUSY_I:  d_issue = memory_ready && d_avail;
            BUSY_D:  i_issue = memory_ready && i_avail;
            default: ;
        endcase
    end

    always_comb begin
        state_next = state_reg;
        if (d_issue) begin
            state_next = BUSY_D;
        end else if (i_issue) begin
            state_next = BUSY_I;
        end else if (i_done || d_done) begin
            state_next = IDLE;
        end
    end

    assign grant_req = d_issue ? d_req : i_req;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_reg    <= IDLE;
            memory_valid <= 1'b0;
            memory_instr <= 1'b0;
            memory_addr  <= '0;
            memory_wdata <= '0;
            memory_wstrb <= '0;
        end else begin
            state_reg    <= state_next;
            memory_valid <= i_issue || d_issue;
            if (i_issue || d_issue) begin
                memory_instr <= i_issue;
                memory_addr  <= grant_req.addr;
                memory_wdata <= grant_req.wdata;
                memory_wstrb <= d_issue ? grant_req.wstrb : 4'd0;
            end
        end
    end

    assign imem_ready = i_done;
    assign dmem_ready = d_done;
    assign imem_rdata = i_done ? memory_rdata : 32'd0;
    assign dmem_rdata = d_done ? memory_rdata : 32'd0;

endmodule

// File: tb/tb_memory_arbiter.sv
// Scoreboard bench for memory_arbiter: directed requests push expected memory
// transactions and responses; a negedge monitor pops and compares them.
module tb_memory_arbiter;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        imem_valid = 1'b0;
    logic [31:0] imem_addr = '0;
    logic [31:0] imem_rdata;
    logic        imem_ready;
    logic        dmem_valid = 1'b0;
    logic [31:0] dmem_addr = '0;
    logic [31:0] dmem_wdata = '0;
    logic [3:0]  dmem_wstrb = '0;
    logic [31:0] dmem_rdata;
    logic        dmem_ready;
    logic        memory_valid;
    logic        memory_instr;
    logic [31:0] memory_addr;
    logic [31:0] memory_wdata;
    logic [3:0]  memory_wstrb;
    logic [31:0] memory_rdata = '0;
    logic        memory_ready = 1'b0;

    memory_arbiter dut (
        .clk          (clk),
        .rst          (rst_n),
        .imem_valid   (imem_valid),
        .imem_addr    (imem_addr),
        .imem_rdata   (imem_rdata),
        .imem_ready   (imem_ready),
        .dmem_valid   (dmem_valid),
        .dmem_addr    (dmem_addr),
        .dmem_wdata   (dmem_wdata),
        .dmem_wstrb   (dmem_wstrb),
        .dmem_rdata   (dmem_rdata),
        .dmem_ready   (dmem_ready),
        .memory_valid (memory_valid),
        .memory_instr (memory_instr),
        .memory_addr  (memory_addr),
        .memory_wdata (memory_wdata),
        .memory_wstrb (memory_wstrb),
        .memory_rdata (memory_rdata),
        .memory_ready (memory_ready)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks = 0;
    int fails = 0;

    typedef struct packed {
        logic        instr;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  wstrb;
        logic [31:0] at;
    } txn_t;

    typedef struct packed {
        logic [31:0] data;
        logic [31:0] at;
    } rsp_t;

    txn_t mq[$];
    rsp_t iq[$];
    rsp_t dq[$];

    // Memory model: word array, ready a programmable number of cycles after issue.
    logic [31:0] mem [0:4095];
    int          countdown = 0;
    int          delay = 1;
    logic [31:0] pend_rdata = '0;

    initial begin
        for (int i = 0; i < 4096; i++) mem[i] = 32'hA500_0000 | i;
    end

    always @(posedge clk) begin
        logic [11:0] idx;
        #1;
        memory_ready = 1'b0;
        memory_rdata = 32'd0;
        if (countdown > 0) begin
            countdown--;
            if (countdown == 0) begin
                memory_ready = 1'b1;
                memory_rdata = pend_rdata;
            end
        end
        if (memory_valid) begin
            idx = memory_addr[13:2];
            if (memory_wstrb == 4'd0) begin
                pend_rdata = mem[idx];
            end else begin
                for (int b = 0; b < 4; b++)
                    if (memory_wstrb[b]) mem[idx][8*b +: 8] = memory_wdata[8*b +: 8];
                pend_rdata = 32'd0;
            end
            countdown = delay;
        end
    end

    always @(negedge clk) begin
        txn_t got_t, exp_t;
        rsp_t got_r, exp_r;
        if (rst_n) begin
            if (memory_valid) begin
                checks++;
                got_t = '{memory_instr, memory_addr, memory_wdata, memory_wstrb, 32'(cyc)};
                if (mq.size() == 0) begin
                    fails++;
                    $display("FAIL mem_txn: unexpected issue instr=%0d addr=%h at cycle %0d, required none",
                             memory_instr, memory_addr, cyc);
                end else begin
                    exp_t = mq.pop_front();
                    if (got_t !== exp_t) begin
                        fails++;
                        $display("FAIL mem_txn: got instr=%0d addr=%h wdata=%h wstrb=%h cyc=%0d, required instr=%0d addr=%h wdata=%h wstrb=%h cyc=%0d",
                                 got_t.instr, got_t.addr, got_t.wdata, got_t.wstrb, got_t.at,
                                 exp_t.instr, exp_t.addr, exp_t.wdata, exp_t.wstrb, exp_t.at);
                    end
                end
            end
            if (imem_ready) begin
                checks++;
                got_r = '{imem_rdata, 32'(cyc)};
                if (iq.size() == 0) begin
                    fails++;
                    $display("FAIL imem_rsp: unexpected ready at cycle %0d, required none", cyc);
                end else begin
                    exp_r = iq.pop_front();
                    if (got_r !== exp_r) begin
                        fails++;
                        $display("FAIL imem_rsp: got rdata=%h cyc=%0d, required rdata=%h cyc=%0d",
                                 got_r.data, got_r.at, exp_r.data, exp_r.at);
                    end
                end
            end else begin
                checks++;
                if (imem_rdata !== 32'd0) begin
                    fails++;
                    $display("FAIL imem_rdata_idle: got %h, required 0", imem_rdata);
                end
            end
            if (dmem_ready) begin
                checks++;
                got_r = '{dmem_rdata, 32'(cyc)};
                if (dq.size() == 0) begin
                    fails++;
                    $display("FAIL dmem_rsp: unexpected ready at cycle %0d, required none", cyc);
                end else begin
                    exp_r = dq.pop_front();
                    if (got_r !== exp_r) begin
                        fails++;
                        $display("FAIL dmem_rsp: got rdata=%h cyc=%0d, required rdata=%h cyc=%0d",
                                 got_r.data, got_r.at, exp_r.data, exp_r.at);
                    end
                end
            end else begin
                checks++;
                if (dmem_rdata !== 32'd0) begin
                    fails++;
                    $display("FAIL dmem_rdata_idle: got %h, required 0", dmem_rdata);
                end
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic push_mem(input logic instr, input logic [31:0] addr, input logic [31:0] wdata,
                            input logic [3:0] wstrb, input int at);
        mq.push_back('{instr, addr, wdata, wstrb, 32'(at)});
    endtask

    task automatic push_rsp(input logic dport, input logic [31:0] data, input int at);
        if (dport) dq.push_back('{data, 32'(at)});
        else       iq.push_back('{data, 32'(at)});
    endtask

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %h, required %h", name, got, exp);
        end
    endtask

    task automatic check_outputs_zero(input string tag);
        check({tag, "_memory_valid"}, {31'd0, memory_valid}, 32'd0);
        check({tag, "_memory_instr"}, {31'd0, memory_instr}, 32'd0);
        check({tag, "_memory_addr"},  memory_addr, 32'd0);
        check({tag, "_memory_wdata"}, memory_wdata, 32'd0);
        check({tag, "_memory_wstrb"}, {28'd0, memory_wstrb}, 32'd0);
        check({tag, "_imem_ready"},   {31'd0, imem_ready}, 32'd0);
        check({tag, "_dmem_ready"},   {31'd0, dmem_ready}, 32'd0);
    endtask

    task automatic drain(input int budget);
        int n = 0;
        while ((mq.size() + iq.size() + dq.size()) != 0 && n < budget) begin
            step();
            n++;
        end
        checks++;
        if ((mq.size() + iq.size() + dq.size()) != 0) begin
            fails++;
            $display("FAIL drain_timeout: got %0d outstanding, required 0",
                     mq.size() + iq.size() + dq.size());
            mq.delete();
            iq.delete();
            dq.delete();
        end
        repeat (2) step();
    endtask

    task automatic drive_i(input logic [31:0] addr);
        imem_valid = 1'b1;
        imem_addr  = addr;
    endtask

    task automatic drive_d(input logic [31:0] addr, input logic [31:0] wdata, input logic [3:0] wstrb);
        dmem_valid = 1'b1;
        dmem_addr  = addr;
        dmem_wdata = wdata;
        dmem_wstrb = wstrb;
    endtask

    task automatic clear_inputs();
        imem_valid = 1'b0;
        dmem_valid = 1'b0;
    endtask

    initial begin
        int c;
        repeat (3) step();
        check_outputs_zero("reset");
        rst_n = 1'b1;
        step();

        // Idle fetch
        c = cyc;
        push_mem(1'b1, 32'h100, 32'd0, 4'd0, c + 1);
        push_rsp(1'b0, 32'hA500_0040, c + 2);
        drive_i(32'h100);
        step();
        clear_inputs();
        drain(20);
        $display("txn idle_fetch done at cycle %0d", cyc);

        // Simultaneous fetch and store: data granted first in both builds here
        c = cyc;
        push_mem(1'b0, 32'h1000, 32'h1, 4'hF, c + 1);
        push_rsp(1'b1, 32'd0, c + 2);
        push_mem(1'b1, 32'h0, 32'd0, 4'd0, c + 3);
        push_rsp(1'b0, 32'hA500_0000, c + 4);
        drive_i(32'h0);
        drive_d(32'h1000, 32'h1, 4'hF);
        step();
        clear_inputs();
        drain(20);
        $display("txn conflict_store_fetch done at cycle %0d", cyc);

        // Load arrives while a fetch is in flight
        c = cyc;
        push_mem(1'b1, 32'h8, 32'd0, 4'd0, c + 1);
        push_rsp(1'b0, 32'hA500_0002, c + 2);
        push_mem(1'b0, 32'h1000, 32'd0, 4'd0, c + 3);
        push_rsp(1'b1, 32'h0000_0001, c + 4);
        drive_i(32'h8);
        step();
        clear_inputs();
        drive_d(32'h1000, 32'd0, 4'd0);
        step();
        clear_inputs();
        drain(20);
        $display("txn load_during_fetch done at cycle %0d", cyc);

        // Byte store then readback
        c = cyc;
        push_mem(1'b0, 32'h200, 32'h0000_AB00, 4'h2, c + 1);
        push_rsp(1'b1, 32'd0, c + 2);
        drive_d(32'h200, 32'h0000_AB00, 4'h2);
        step();
        clear_inputs();
        drain(20);
        c = cyc;
        push_mem(1'b0, 32'h200, 32'd0, 4'd0, c + 1);
        push_rsp(1'b1, 32'hA500_AB80, c + 2);
        drive_d(32'h200, 32'd0, 4'd0);
        step();
        clear_inputs();
        drain(20);
        $display("txn byte_store_readback done at cycle %0d", cyc);

        // Repeat conflict: last grant was data
        c = cyc;
`ifdef ARBITER_RR_EN
        push_mem(1'b1, 32'h4, 32'd0, 4'd0, c + 1);
        push_rsp(1'b0, 32'hA500_0001, c + 2);
        push_mem(1'b0, 32'h1000, 32'd0, 4'd0, c + 3);
        push_rsp(1'b1, 32'h0000_0001, c + 4);
`else
        push_mem(1'b0, 32'h1000, 32'd0, 4'd0, c + 1);
        push_rsp(1'b1, 32'h0000_0001, c + 2);
        push_mem(1'b1, 32'h4, 32'd0, 4'd0, c + 3);
        push_rsp(1'b0, 32'hA500_0001, c + 4);
`endif
        drive_i(32'h4);
        drive_d(32'h1000, 32'd0, 4'd0);
        step();
        clear_inputs();
        drain(20);
        $display("txn conflict_load_fetch done at cycle %0d", cyc);

        // New fetch in the same cycle as the previous fetch's ready
        c = cyc;
        push_mem(1'b1, 32'h20, 32'd0, 4'd0, c + 1);
        push_rsp(1'b0, 32'hA500_0008, c + 2);
        push_mem(1'b1, 32'h24, 32'd0, 4'd0, c + 4);
        push_rsp(1'b0, 32'hA500_0009, c + 5);
        drive_i(32'h20);
        step();
        clear_inputs();
        step();
        drive_i(32'h24);
        step();
        clear_inputs();
        drain(20);
        $display("txn fetch_on_ready done at cycle %0d", cyc);

        // Reset mid-transaction with a late memory_ready after release
        delay = 4;
        c = cyc;
        push_mem(1'b1, 32'h10, 32'd0, 4'd0, c + 1);
        drive_i(32'h10);
        step();
        clear_inputs();
        step();
        rst_n = 1'b0;
        #1;
        check_outputs_zero("midreset");
        repeat (2) step();
        rst_n = 1'b1;
        delay = 1;
        repeat (3) step();
        c = cyc;
        push_mem(1'b1, 32'h14, 32'd0, 4'd0, c + 1);
        push_rsp(1'b0, 32'hA500_0005, c + 2);
        drive_i(32'h14);
        step();
        clear_inputs();
        drain(20);
        $display("txn reset_recovery done at cycle %0d", cyc);

        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
